// File: rtl/silly_pattern_engine_pkg.sv
// Package silly_pkg: shared types and helpers for the silly pattern engine.
//  mode_e    : pattern mode (COUNT / BOUNCE / LFSR / ROTATE), matches the 2-bit mode input.
//  state_e   : control FSM state (IDLE / RUN / SINGLE), exposed on the dbg_state output.
//  lfsr_taps : maximal-length Galois (right-shift) toggle masks for widths 4..16.
package silly_pkg;

  typedef enum logic [1:0] {
    COUNT  = 2'd0,
    BOUNCE = 2'd1,
    LFSR   = 2'd2,
    ROTATE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SINGLE = 2'd2
  } state_e;

  // Toggle mask applied when the bit shifted out of bit 0 is 1.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] taps;
    case (w)
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h00B8;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/silly_pattern_engine_if.sv
// Interface bundling the control/observation signals of silly_pattern_engine.
//  master : driver side (wrapper or bench) - drives controls, observes outputs.
//  slave  : engine side.
// Handshake: there is no valid/ready pair here; run is a level, step and
// seed_load are single-cycle pulses sampled on the rising clock edge whenever
// ena is 1, and tick is a one-cycle pulse marking a pattern advance.
// Optional: SILLY_PWM_EN adds the 4-bit duty input.
interface silly_pattern_engine_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 5
);
  logic             ena;
  logic [1:0]       mode;
  logic             run;
  logic             step;
  logic [DIV_W-1:0] div_sel;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
`ifdef SILLY_PWM_EN
  logic [3:0]       duty;
`endif
  logic [WIDTH-1:0] pat_out;
  logic             tick;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
`ifdef SILLY_PWM_EN
    output duty,
`endif
    output ena, mode, run, step, div_sel, seed_load, seed,
    input  pat_out, tick, busy, dbg_state
  );

  modport slave (
`ifdef SILLY_PWM_EN
    input  duty,
`endif
    input  ena, mode, run, step, div_sel, seed_load, seed,
    output pat_out, tick, busy, dbg_state
  );
endinterface

// File: rtl/silly_pattern_engine_prescaler.sv
// silly_prescaler: tick-period generator for the pattern engine.
//  clk, rst : clock, async active-high reset
//  ena      : global enable; 0 freezes the counter
//  clr      : synchronous clear (takes effect only while ena=1)
//  div_sel  : period = 2^div_sel cycles, clamped to 2^(PRESC_W-1)
//  tc       : terminal-count pulse, combinational, already gated by ena/clr
module silly_prescaler #(
  parameter int PRESC_W = 24,
  parameter int DIV_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_sel,
  output logic             tc
);
  localparam logic [DIV_W-1:0] SEL_MAX = DIV_W'(PRESC_W - 1);

  logic [PRESC_W-1:0] r_cnt;
  logic [PRESC_W-1:0] w_lim;
  logic [DIV_W-1:0]   w_sel;
  logic               w_at_lim;

  always_comb begin
    w_sel = (div_sel > SEL_MAX) ? SEL_MAX : div_sel;
    w_lim = (PRESC_W'(1) << w_sel) - PRESC_W'(1);
  end

  // >= rather than == so a div_sel shrink mid-count wraps immediately
  // instead of running the counter all the way round.
  assign w_at_lim = (r_cnt >= w_lim);
  assign tc       = ena && !clr && w_at_lim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (ena) begin
      if (clr || w_at_lim) r_cnt <= '0;
      else                 r_cnt <= r_cnt + PRESC_W'(1);
    end
  end
endmodule

// File: rtl/silly_pattern_engine.sv
// silly_pattern_engine: WIDTH-bit pattern generator (count / bounce / LFSR /
// rotate) advancing on a prescaled tick, with free-run, single-step and seed load.
//  clk : clock
//  rst : asynchronous active-high reset
//  bus : silly_pattern_engine_if.slave - ena, mode, run, step, div_sel,
//        seed_load, seed in; pat_out, tick, busy, dbg_state out.
// Optional feature macro SILLY_PWM_EN: pat_out is gated by a 4-bit PWM
// (duty input on the interface); without it pat_out is the pattern register.
module silly_pattern_engine
  import silly_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 24,
  parameter int DIV_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  silly_pattern_engine_if.slave bus
);
  localparam logic [1:0]       ST_IDLE   = IDLE;
  localparam logic [1:0]       ST_RUN    = RUN;
  localparam logic [1:0]       ST_SINGLE = SINGLE;
  localparam logic [WIDTH-1:0] TAPS      = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [1:0]       r_state, w_state_nxt;
  mode_e            r_mode_q, w_mode;
  logic [WIDTH-1:0] r_pat, r_seed_reg;
  logic             r_dir_left, r_tick;
  logic [WIDTH-1:0] w_adv_pat, w_init_pat, w_seed_pat, w_lfsr_src;
  logic             w_dir_nxt, w_go_left;
  logic             w_mode_chg, w_run_active, w_presc_clr, w_tc, w_adv;

  assign w_mode       = mode_e'(bus.mode);
  assign w_mode_chg   = (w_mode != r_mode_q);
  assign w_run_active = (r_state == ST_RUN) && bus.run;
  assign w_presc_clr  = !w_run_active || w_mode_chg;

  silly_prescaler #(.PRESC_W(PRESC_W), .DIV_W(DIV_W)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .ena     (bus.ena),
    .clr     (w_presc_clr),
    .div_sel (bus.div_sel),
    .tc      (w_tc)
  );

  // Advance request; seed_load / mode change override it in the register block
  // and the request is simply dropped.
  assign w_adv = (r_state == ST_SINGLE) || (w_run_active && w_tc);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.run) w_state_nxt = ST_RUN;
                 else if (bus.step) w_state_nxt = ST_SINGLE;
      ST_RUN:    if (!bus.run) w_state_nxt = ST_IDLE;
      ST_SINGLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_lfsr_src = (r_pat == '0) ? ONE : r_pat;
    // Direction is re-derived from the pattern so a seeded one-hot sitting on
    // the MSB with dir=left still turns back instead of shifting out.
    w_go_left  = r_dir_left ? !r_pat[WIDTH-1] : r_pat[0];
    w_adv_pat  = r_pat;
    w_dir_nxt  = r_dir_left;
    case (r_mode_q)
      COUNT:  w_adv_pat = r_pat + ONE;
      BOUNCE: begin
        w_adv_pat = w_go_left ? (r_pat << 1) : (r_pat >> 1);
        // Flip when the shifted bit lands on an end.
        w_dir_nxt = w_go_left ? !r_pat[WIDTH-2] : r_pat[1];
      end
      LFSR:   w_adv_pat = (w_lfsr_src >> 1) ^ (w_lfsr_src[0] ? TAPS : '0);
      ROTATE: w_adv_pat = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};
      default: w_adv_pat = r_pat;
    endcase

    case (w_mode)
      COUNT:   w_init_pat = '0;
      BOUNCE:  w_init_pat = ONE;
      LFSR:    w_init_pat = ONE;
      ROTATE:  w_init_pat = r_seed_reg;
      default: w_init_pat = '0;
    endcase

    w_seed_pat = bus.seed;
    if (w_mode == LFSR && bus.seed == '0)       w_seed_pat = ONE;
    if (w_mode == BOUNCE && !$onehot(bus.seed)) w_seed_pat = ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mode_q   <= COUNT;
      r_pat      <= '0;
      r_dir_left <= 1'b1;
      r_seed_reg <= ONE;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (bus.ena) begin
        r_state  <= w_state_nxt;
        r_mode_q <= w_mode;
        if (bus.seed_load) begin
          r_pat      <= w_seed_pat;
          r_seed_reg <= bus.seed;
          r_dir_left <= 1'b1;
        end else if (w_mode_chg) begin
          r_pat      <= w_init_pat;
          r_dir_left <= 1'b1;
        end else if (w_adv) begin
          r_pat      <= w_adv_pat;
          r_dir_left <= w_dir_nxt;
          r_tick     <= 1'b1;
        end
      end
    end
  end

`ifdef SILLY_PWM_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_pwm_cnt <= 4'd0;
    else if (bus.ena) r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end

  // duty=15 keeps the output on every cycle, duty=0 gives 1 cycle in 16.
  assign bus.pat_out = r_pat & {WIDTH{r_pwm_cnt <= bus.duty}};
`else
  assign bus.pat_out = r_pat;
`endif

  assign bus.tick      = r_tick;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.dbg_state = r_state;
endmodule
